// File: rtl/rvcpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// rvcpu_mem_pkg : shared types and constants for the memory-access stages
// Rev 1.0
// ============================================================================
package rvcpu_mem_pkg;

    typedef enum logic [1:0] {
        BYTE   = 2'b00,
        HALF   = 2'b01,
        WORD   = 2'b10,
        DOUBLE = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        HOLD = 2'b10
    } memp_state_e;

    localparam logic [63:0] c_DRAM_BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] c_DRAM_SIZE = 64'h0000_0000_0800_0000;

    // Control/data fields that travel with an instruction into stage 8
    typedef struct packed {
        logic [63:0] pc;
        logic [1:0]  rf_wr_sel;
        logic        rf_wr_en;
        logic [63:0] alu_result;
        logic [4:0]  rd;
    } memp_bundle_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_memp_stage7_store_align.sv
`default_nettype none
// ============================================================================
// store_align : byte-lane mask, lane-shifted data and misalignment detection
// Rev 1.0
// ============================================================================
module store_align
    import rvcpu_mem_pkg::*;
(
    input  logic [2:0]  addr_lo,
    input  mem_size_e   size,
    input  logic [63:0] data,
    output logic [7:0]  wmask,
    output logic [63:0] wdata,
    output logic        misalign
);

    always_comb begin
        wmask    = 8'h00;
        misalign = 1'b0;
        case (size)
            BYTE: begin
                wmask = 8'h01 << addr_lo;
            end
            HALF: begin
                wmask    = 8'h03 << addr_lo;
                misalign = addr_lo[0];
            end
            WORD: begin
                wmask    = 8'h0F << addr_lo;
                misalign = |addr_lo[1:0];
            end
            DOUBLE: begin
                wmask    = 8'hFF;
                misalign = |addr_lo;
            end
            default: begin
                wmask    = 8'h00;
                misalign = 1'b0;
            end
        endcase
    end

    assign wdata = data << {addr_lo, 3'b000};

endmodule
`default_nettype wire

// File: rtl/pipeline_memp_stage7.sv
`default_nettype none
// ============================================================================
// pipeline_memp_stage7 : memory-prepare stage (address decode, store align,
// DRAM req/ack issue, system-bus strobes, stage-8 bundle register). Rev 1.0
// ============================================================================
module pipeline_memp_stage7
    import rvcpu_mem_pkg::*;
#(
    parameter logic [63:0] DRAM_BASE = c_DRAM_BASE,
    parameter logic [63:0] DRAM_SIZE = c_DRAM_SIZE
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [63:0] pc_MEM,
    input  logic [1:0]  rf_wr_sel_MEM,
    input  logic        rf_wr_en_MEM,
    input  logic [63:0] alu_result_MEM,
    input  logic [4:0]  rd_MEM,
    input  logic        mem_rd_en_MEM,
    input  logic        mem_wr_en_MEM,
    input  logic [1:0]  mem_size_MEM,
    input  logic [63:0] store_data_MEM,
    output logic        dram_req,
    output logic        dram_we,
    output logic [63:0] dram_addr,
    output logic [63:0] dram_wdata,
    output logic [7:0]  dram_wmask,
    input  logic        dram_ack,
    output logic        sys_bus_re,
    output logic        sys_bus_we,
    output logic [63:0] sys_bus_addr,
    output logic [63:0] sys_bus_wdata,
    output logic [7:0]  sys_bus_wmask,
    output logic        stall_req,
    output logic        misalign_MEMP,
    output logic        is_dram_MEMP,
    output logic [63:0] pc_MEMP,
    output logic [1:0]  rf_wr_sel_MEMP,
    output logic        rf_wr_en_MEMP,
    output logic [63:0] alu_result_MEMP,
    output logic [4:0]  rd_MEMP
);

    localparam logic [63:0] c_DRAM_END = DRAM_BASE + DRAM_SIZE;

    memp_state_e  r_state;
    memp_bundle_t r_pend;
    memp_bundle_t r_out;
    logic         r_misalign;
    logic         r_is_dram;
    logic         r_dram_req;
    logic         r_dram_we;
    logic [63:0]  r_dram_addr;
    logic [63:0]  r_dram_wdata;
    logic [7:0]   r_dram_wmask;

    logic [7:0]   w_wmask;
    logic [63:0]  w_wdata;
    logic         w_mis_raw;
    logic         w_acc;
    logic         w_in_dram;
    logic         w_misalign;
    logic         w_idle_go;
    logic         w_dram_issue;
    logic         w_sys_go;
    memp_bundle_t w_in_bundle;
    memp_bundle_t w_pass_bundle;

    store_align u_store_align (
        .addr_lo  (alu_result_MEM[2:0]),
        .size     (mem_size_e'(mem_size_MEM)),
        .data     (store_data_MEM),
        .wmask    (w_wmask),
        .wdata    (w_wdata),
        .misalign (w_mis_raw)
    );

    assign w_acc        = mem_rd_en_MEM | mem_wr_en_MEM;
    assign w_in_dram    = (alu_result_MEM >= DRAM_BASE) && (alu_result_MEM < c_DRAM_END);
    assign w_misalign   = w_acc & w_mis_raw;
    assign w_idle_go    = (r_state == IDLE) & ~stall;
    assign w_dram_issue = w_idle_go & w_acc & w_in_dram & ~w_misalign;
    assign w_sys_go     = w_idle_go & w_acc & ~w_in_dram & ~w_misalign;

    assign w_in_bundle = '{pc:         pc_MEM,
                           rf_wr_sel:  rf_wr_sel_MEM,
                           rf_wr_en:   rf_wr_en_MEM,
                           alu_result: alu_result_MEM,
                           rd:         rd_MEM};

    // A faulting access must not write back
    always_comb begin
        w_pass_bundle          = w_in_bundle;
        w_pass_bundle.rf_wr_en = rf_wr_en_MEM & ~w_misalign;
    end

    assign sys_bus_re    = w_sys_go & mem_rd_en_MEM;
    assign sys_bus_we    = w_sys_go & mem_wr_en_MEM;
    assign sys_bus_addr  = w_sys_go ? alu_result_MEM : 64'd0;
    assign sys_bus_wdata = w_sys_go ? w_wdata : 64'd0;
    assign sys_bus_wmask = w_sys_go ? w_wmask : 8'h00;

    assign stall_req = (r_state == REQ) | (r_state == HOLD) | w_dram_issue;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_pend       <= '0;
            r_out        <= '0;
            r_misalign   <= 1'b0;
            r_is_dram    <= 1'b0;
            r_dram_req   <= 1'b0;
            r_dram_we    <= 1'b0;
            r_dram_addr  <= 64'd0;
            r_dram_wdata <= 64'd0;
            r_dram_wmask <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_dram_issue) begin
                        r_state      <= REQ;
                        r_dram_req   <= 1'b1;
                        r_dram_we    <= mem_wr_en_MEM;
                        r_dram_addr  <= {alu_result_MEM[63:3], 3'b000};
                        r_dram_wdata <= w_wdata;
                        r_dram_wmask <= w_wmask;
                        r_pend       <= w_in_bundle;
                        // Bubble now so the previous instruction is not re-consumed
                        r_out        <= '0;
                        r_misalign   <= 1'b0;
                        r_is_dram    <= 1'b0;
                    end else if (!stall) begin
                        r_out        <= w_pass_bundle;
                        r_misalign   <= w_misalign;
                        r_is_dram    <= 1'b0;
                    end
                end
                REQ: begin
                    if (dram_ack) begin
                        r_dram_req <= 1'b0;
                        if (!stall) begin
                            r_out      <= r_pend;
                            r_misalign <= 1'b0;
                            r_is_dram  <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_state    <= HOLD;
                        end
                    end else if (!stall) begin
                        r_out      <= '0;
                        r_misalign <= 1'b0;
                        r_is_dram  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        r_out      <= r_pend;
                        r_misalign <= 1'b0;
                        r_is_dram  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_dram_req <= 1'b0;
                end
            endcase
        end
    end

    assign dram_req        = r_dram_req;
    assign dram_we         = r_dram_we;
    assign dram_addr       = r_dram_addr;
    assign dram_wdata      = r_dram_wdata;
    assign dram_wmask      = r_dram_wmask;
    assign misalign_MEMP   = r_misalign;
    assign is_dram_MEMP    = r_is_dram;
    assign pc_MEMP         = r_out.pc;
    assign rf_wr_sel_MEMP  = r_out.rf_wr_sel;
    assign rf_wr_en_MEMP   = r_out.rf_wr_en;
    assign alu_result_MEMP = r_out.alu_result;
    assign rd_MEMP         = r_out.rd;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_memp_stage7.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_pipeline_memp_stage7 : vector table, hand sequences and randomized run
// against a transaction-level reference model. Rev 1.0
// ============================================================================
module tb_pipeline_memp_stage7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [63:0] pc_MEM = '0, alu_result_MEM = '0, store_data_MEM = '0;
    logic [1:0]  rf_wr_sel_MEM = '0, mem_size_MEM = '0;
    logic        rf_wr_en_MEM = 1'b0, mem_rd_en_MEM = 1'b0, mem_wr_en_MEM = 1'b0;
    logic [4:0]  rd_MEM = '0;
    logic        dram_ack = 1'b0;
    logic        dram_req, dram_we, sys_bus_re, sys_bus_we, stall_req;
    logic        misalign_MEMP, is_dram_MEMP, rf_wr_en_MEMP;
    logic [63:0] dram_addr, dram_wdata, sys_bus_addr, sys_bus_wdata, pc_MEMP, alu_result_MEMP;
    logic [7:0]  dram_wmask, sys_bus_wmask;
    logic [1:0]  rf_wr_sel_MEMP;
    logic [4:0]  rd_MEMP;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_memp_stage7 dut (
        .clk(clk), .reset(reset), .stall(stall),
        .pc_MEM(pc_MEM), .rf_wr_sel_MEM(rf_wr_sel_MEM), .rf_wr_en_MEM(rf_wr_en_MEM),
        .alu_result_MEM(alu_result_MEM), .rd_MEM(rd_MEM),
        .mem_rd_en_MEM(mem_rd_en_MEM), .mem_wr_en_MEM(mem_wr_en_MEM),
        .mem_size_MEM(mem_size_MEM), .store_data_MEM(store_data_MEM),
        .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr),
        .dram_wdata(dram_wdata), .dram_wmask(dram_wmask), .dram_ack(dram_ack),
        .sys_bus_re(sys_bus_re), .sys_bus_we(sys_bus_we), .sys_bus_addr(sys_bus_addr),
        .sys_bus_wdata(sys_bus_wdata), .sys_bus_wmask(sys_bus_wmask),
        .stall_req(stall_req), .misalign_MEMP(misalign_MEMP), .is_dram_MEMP(is_dram_MEMP),
        .pc_MEMP(pc_MEMP), .rf_wr_sel_MEMP(rf_wr_sel_MEMP), .rf_wr_en_MEMP(rf_wr_en_MEMP),
        .alu_result_MEMP(alu_result_MEMP), .rd_MEMP(rd_MEMP)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] alu;
        logic [63:0] sdata;
        logic [1:0]  sel;
        logic [1:0]  size;
        logic        wen;
        logic        rd_en;
        logic        wr_en;
        logic [4:0]  rd;
    } instr_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] alu;
        logic [1:0]  sel;
        logic        wen;
        logic        mis;
        logic        isd;
        logic [4:0]  rd;
    } outb_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] alu;
        logic [63:0] sdata;
        logic [4:0]  rd;
        logic [1:0]  size;
        logic        rd_en;
        logic        wr_en;
        logic        exp_dram;
        logic        exp_mis;
        logic [7:0]  exp_mask;
        logic [63:0] exp_wdata;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- reference rules (plain arithmetic) ----------------
    function automatic bit ref_is_dram(input logic [63:0] a);
        return (a >= 64'h8000_0000) && (a < 64'h8000_0000 + 64'h0800_0000);
    endfunction

    function automatic bit ref_mis(input logic [63:0] a, input logic [1:0] sz);
        int nb;
        nb = 1 << sz;
        return (int'(a[2:0]) % nb) != 0;
    endfunction

    function automatic logic [7:0] ref_mask(input logic [63:0] a, input logic [1:0] sz);
        int nb;
        logic [15:0] m;
        nb = 1 << sz;
        if (nb == 8) return 8'hFF;
        m = 16'((1 << nb) - 1);
        m = m << a[2:0];
        return m[7:0];
    endfunction

    function automatic logic [63:0] ref_wdata(input logic [63:0] a, input logic [63:0] d);
        return d << (8 * int'(a[2:0]));
    endfunction

    function automatic outb_t mk_out(input instr_t i, input bit mis, input bit isd);
        outb_t o;
        o.pc = i.pc; o.alu = i.alu; o.sel = i.sel; o.rd = i.rd;
        o.wen = i.wen & ~mis; o.mis = mis; o.isd = isd;
        return o;
    endfunction

    task automatic present(input instr_t i);
        pc_MEM = i.pc; alu_result_MEM = i.alu; store_data_MEM = i.sdata;
        rf_wr_sel_MEM = i.sel; mem_size_MEM = i.size; rf_wr_en_MEM = i.wen;
        mem_rd_en_MEM = i.rd_en; mem_wr_en_MEM = i.wr_en; rd_MEM = i.rd;
    endtask

    task automatic present_nop(input logic [63:0] pc);
        instr_t n;
        n = '0; n.pc = pc; n.alu = 64'h55; n.wen = 1'b1; n.rd = 5'd9;
        present(n);
    endtask

    task automatic chk_out(input string tag, input outb_t e);
        chk({tag, ".pc"}, pc_MEMP, e.pc);
        chk({tag, ".alu"}, alu_result_MEMP, e.alu);
        chk({tag, ".ctl"}, {rf_wr_sel_MEMP, rf_wr_en_MEMP, misalign_MEMP, is_dram_MEMP, rd_MEMP},
            {e.sel, e.wen, e.mis, e.isd, e.rd});
    endtask

    task automatic do_reset();
        reset = 1'b0; stall = 1'b0; dram_ack = 1'b0;
        present_nop(64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- table-driven single-access vectors ----------------
    vec_t vecs[11];

    task automatic apply_vec(input int idx, input vec_t v);
        instr_t i;
        bit acc, issue, sys;
        i = '0; i.pc = v.pc; i.alu = v.alu; i.sdata = v.sdata; i.sel = 2'b01;
        i.size = v.size; i.wen = 1'b1; i.rd_en = v.rd_en; i.wr_en = v.wr_en; i.rd = v.rd;
        present(i); stall = 1'b0; dram_ack = 1'b0;
        acc   = v.rd_en | v.wr_en;
        issue = acc & v.exp_dram & ~v.exp_mis;
        sys   = acc & ~v.exp_dram & ~v.exp_mis;
        #1;
        chk($sformatf("vec%0d.stall_req", idx), stall_req, issue);
        chk($sformatf("vec%0d.sys_re", idx), sys_bus_re, sys & v.rd_en);
        chk($sformatf("vec%0d.sys_we", idx), sys_bus_we, sys & v.wr_en);
        if (sys) begin
            chk($sformatf("vec%0d.sys_addr", idx), sys_bus_addr, v.alu);
            chk($sformatf("vec%0d.sys_mask", idx), sys_bus_wmask, v.exp_mask);
            chk($sformatf("vec%0d.sys_wdata", idx), sys_bus_wdata, v.exp_wdata);
        end
        @(posedge clk); #1;
        if (issue) begin
            chk($sformatf("vec%0d.dram_req", idx), dram_req, 1'b1);
            chk($sformatf("vec%0d.dram_we", idx), dram_we, v.wr_en);
            chk($sformatf("vec%0d.dram_addr", idx), dram_addr, {v.alu[63:3], 3'b000});
            chk($sformatf("vec%0d.dram_mask", idx), dram_wmask, v.exp_mask);
            chk($sformatf("vec%0d.dram_wdata", idx), dram_wdata, v.exp_wdata);
            chk($sformatf("vec%0d.bubble", idx), {pc_MEMP[7:0], rf_wr_en_MEMP, is_dram_MEMP}, 10'd0);
            present_nop(64'h4);
            dram_ack = 1'b1;
            @(posedge clk); #1;
            dram_ack = 1'b0;
            chk($sformatf("vec%0d.req_drop", idx), dram_req, 1'b0);
            chk_out($sformatf("vec%0d", idx), mk_out(i, 1'b0, 1'b1));
        end else begin
            chk($sformatf("vec%0d.no_req", idx), dram_req, 1'b0);
            chk_out($sformatf("vec%0d", idx), mk_out(i, v.exp_mis, 1'b0));
        end
    endtask

    // ---------------- randomized run state ----------------
    logic [63:0] pc_ctr;

    task automatic rand_instr(output instr_t i);
        int kind;
        i.pc = pc_ctr; pc_ctr = pc_ctr + 64'd4;
        case ($urandom_range(0, 3))
            0:       i.alu = 64'h8000_0000 + 64'($urandom_range(0, 255));
            1:       i.alu = 64'h1000_0000 + 64'($urandom_range(0, 255));
            2:       i.alu = 64'h87FF_FFF8 + 64'($urandom_range(0, 15));
            default: i.alu = {$urandom, $urandom};
        endcase
        kind    = $urandom_range(0, 2);
        i.rd_en = (kind == 1);
        i.wr_en = (kind == 2);
        i.size  = 2'($urandom_range(0, 3));
        i.sdata = {$urandom, $urandom};
        i.sel   = 2'($urandom_range(0, 3));
        i.wen   = 1'($urandom_range(0, 1));
        i.rd    = 5'($urandom_range(0, 31));
    endtask

    initial begin
        instr_t cur, txn, h;
        outb_t  m_out;
        bit     m_busy, m_acked, p_acc, p_dram, p_mis, sysgo, accepted;

        vecs[0]  = '{pc:64'h8000_0010, alu:64'h1234, sdata:64'h0, rd:5'd5, size:2'd0, rd_en:1'b0, wr_en:1'b0,
                     exp_dram:1'b0, exp_mis:1'b0, exp_mask:8'h00, exp_wdata:64'h0};
        vecs[1]  = '{pc:64'h100, alu:64'h1000_0004, sdata:64'h0, rd:5'd1, size:2'd2, rd_en:1'b1, wr_en:1'b0,
                     exp_dram:1'b0, exp_mis:1'b0, exp_mask:8'hF0, exp_wdata:64'h0};
        vecs[2]  = '{pc:64'h110, alu:64'h1000_0006, sdata:64'hBEEF, rd:5'd2, size:2'd1, rd_en:1'b0, wr_en:1'b1,
                     exp_dram:1'b0, exp_mis:1'b0, exp_mask:8'hC0, exp_wdata:64'hBEEF_0000_0000_0000};
        vecs[3]  = '{pc:64'h120, alu:64'h8000_0001, sdata:64'h0, rd:5'd3, size:2'd1, rd_en:1'b1, wr_en:1'b0,
                     exp_dram:1'b1, exp_mis:1'b1, exp_mask:8'h00, exp_wdata:64'h0};
        vecs[4]  = '{pc:64'h130, alu:64'h1000_0008, sdata:64'h0123_4567_89AB_CDEF, rd:5'd4, size:2'd3,
                     rd_en:1'b0, wr_en:1'b1, exp_dram:1'b0, exp_mis:1'b0, exp_mask:8'hFF,
                     exp_wdata:64'h0123_4567_89AB_CDEF};
        vecs[5]  = '{pc:64'h140, alu:64'h8000_0006, sdata:64'h0, rd:5'd6, size:2'd2, rd_en:1'b1, wr_en:1'b0,
                     exp_dram:1'b1, exp_mis:1'b1, exp_mask:8'h00, exp_wdata:64'h0};
        vecs[6]  = '{pc:64'h150, alu:64'h8000_0003, sdata:64'hAB, rd:5'd7, size:2'd0, rd_en:1'b0, wr_en:1'b1,
                     exp_dram:1'b1, exp_mis:1'b0, exp_mask:8'h08, exp_wdata:64'hAB00_0000};
        vecs[7]  = '{pc:64'h160, alu:64'h87FF_FFF8, sdata:64'h0, rd:5'd8, size:2'd3, rd_en:1'b1, wr_en:1'b0,
                     exp_dram:1'b1, exp_mis:1'b0, exp_mask:8'hFF, exp_wdata:64'h0};
        vecs[8]  = '{pc:64'h170, alu:64'h8800_0000, sdata:64'h0, rd:5'd9, size:2'd3, rd_en:1'b1, wr_en:1'b0,
                     exp_dram:1'b0, exp_mis:1'b0, exp_mask:8'hFF, exp_wdata:64'h0};
        vecs[9]  = '{pc:64'h180, alu:64'h7FFF_FFFC, sdata:64'h1122_3344, rd:5'd10, size:2'd2, rd_en:1'b0,
                     wr_en:1'b1, exp_dram:1'b0, exp_mis:1'b0, exp_mask:8'hF0, exp_wdata:64'h1122_3344_0000_0000};
        vecs[10] = '{pc:64'h190, alu:64'h1000_0004, sdata:64'h77, rd:5'd11, size:2'd3, rd_en:1'b0, wr_en:1'b1,
                     exp_dram:1'b0, exp_mis:1'b1, exp_mask:8'h00, exp_wdata:64'h0};

        // Reset state
        do_reset();
        #1;
        chk("reset.out", {pc_MEMP, rd_MEMP, rf_wr_en_MEMP, is_dram_MEMP, misalign_MEMP}, 64'd0);
        chk("reset.dram_req", dram_req, 1'b0);

        for (int k = 0; k < 11; k++) apply_vec(k, vecs[k]);

        // Store byte, ack arrives in the third request cycle
        h = '0; h.pc = 64'h200; h.alu = 64'h8000_0003; h.sdata = 64'hAB; h.wr_en = 1'b1; h.rd = 5'd0;
        present(h); stall = 1'b0; dram_ack = 1'b0;
        #1 chk("sb.stall_req0", stall_req, 1'b1);
        @(posedge clk); #1;
        chk("sb.req", dram_req, 1'b1);
        chk("sb.addr", dram_addr, 64'h8000_0000);
        chk("sb.mask", dram_wmask, 8'h08);
        chk("sb.wdata", dram_wdata[31:24], 8'hAB);
        present_nop(64'h204);
        for (int k = 0; k < 2; k++) begin
            chk("sb.stall_req", stall_req, 1'b1);
            @(posedge clk); #1;
            chk("sb.req_held", dram_req, 1'b1);
            chk("sb.bubble", {pc_MEMP, rf_wr_en_MEMP, is_dram_MEMP}, 66'd0);
        end
        dram_ack = 1'b1;
        @(posedge clk); #1;
        dram_ack = 1'b0;
        chk("sb.req_drop", dram_req, 1'b0);
        chk("sb.done", {pc_MEMP[15:0], is_dram_MEMP}, {16'h0200, 1'b1});
        @(posedge clk); #1;
        chk("sb.next", {pc_MEMP[15:0], is_dram_MEMP, rd_MEMP}, {16'h0204, 1'b0, 5'd9});

        // DRAM load, stall during REQ, ack while stalled -> HOLD -> release
        h = '0; h.pc = 64'h300; h.alu = 64'h8000_0040; h.rd_en = 1'b1; h.size = 2'd3; h.wen = 1'b1; h.rd = 5'd7;
        present(h);
        @(posedge clk); #1;
        chk("st.req", dram_req, 1'b1);
        stall = 1'b1; present_nop(64'h304);
        @(posedge clk); #1;
        chk("st.req_kept", dram_req, 1'b1);
        dram_ack = 1'b1;
        @(posedge clk); #1;
        dram_ack = 1'b0;
        chk("st.hold_req", {dram_req, stall_req}, 2'b01);
        chk("st.hold_out", {pc_MEMP, is_dram_MEMP}, 65'd0);
        @(posedge clk); #1;
        chk("st.hold2", {stall_req, is_dram_MEMP}, 2'b10);
        stall = 1'b0;
        @(posedge clk); #1;
        chk_out("st.rel", mk_out(h, 1'b0, 1'b1));
        chk("st.idle", stall_req, 1'b0);

        // Asynchronous reset while a request is outstanding
        present(h);
        @(posedge clk); #1;
        chk("rr.req", dram_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("rr.req0", dram_req, 1'b0);
        chk("rr.out0", {pc_MEMP, rd_MEMP, rf_wr_en_MEMP, is_dram_MEMP, misalign_MEMP}, 64'd0);
        present_nop(64'h400);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("rr.idle", {dram_req, stall_req}, 2'b00);
        h = '0; h.pc = 64'h404; h.alu = 64'h1000_0010; h.rd_en = 1'b1; h.size = 2'd2;
        present(h);
        #1 chk("rr.sys_re", sys_bus_re, 1'b1);

        // Randomized run against the transaction-level model
        do_reset();
        #1;
        m_out = '0; m_busy = 1'b0; m_acked = 1'b0; txn = '0;
        pc_ctr = 64'h1000;
        rand_instr(cur); present(cur);
        for (int c = 0; c < 1500; c++) begin
            stall    = ($urandom_range(0, 3) == 0);
            dram_ack = m_busy && !m_acked && ($urandom_range(0, 2) == 0);
            #1;
            p_acc  = cur.rd_en | cur.wr_en;
            p_dram = ref_is_dram(cur.alu);
            p_mis  = p_acc && ref_mis(cur.alu, cur.size);
            chk("rnd.stall_req", stall_req, m_busy || (!stall && p_acc && p_dram && !p_mis));
            chk("rnd.dram_req", dram_req, m_busy && !m_acked);
            if (m_busy && !m_acked) begin
                chk("rnd.dram_addr", dram_addr, {txn.alu[63:3], 3'b000});
                chk("rnd.dram_we", dram_we, txn.wr_en);
                chk("rnd.dram_mask", dram_wmask, ref_mask(txn.alu, txn.size));
                chk("rnd.dram_wdata", dram_wdata, ref_wdata(txn.alu, txn.sdata));
            end
            sysgo = !m_busy && !stall && p_acc && !p_dram && !p_mis;
            chk("rnd.sys_strobes", {sys_bus_re, sys_bus_we}, {sysgo & cur.rd_en, sysgo & cur.wr_en});
            if (sysgo) begin
                chk("rnd.sys_addr", sys_bus_addr, cur.alu);
                chk("rnd.sys_mask", sys_bus_wmask, ref_mask(cur.alu, cur.size));
                chk("rnd.sys_wdata", sys_bus_wdata, ref_wdata(cur.alu, cur.sdata));
            end
            @(posedge clk); #1;
            accepted = 1'b0;
            if (m_busy) begin
                if (dram_ack) m_acked = 1'b1;
                if (!stall) begin
                    if (m_acked) begin
                        m_out = mk_out(txn, 1'b0, 1'b1);
                        m_busy = 1'b0; m_acked = 1'b0;
                    end else begin
                        m_out = '0;
                    end
                end
            end else if (!stall) begin
                accepted = 1'b1;
                if (p_acc && p_dram && !p_mis) begin
                    m_busy = 1'b1; m_acked = 1'b0; txn = cur; m_out = '0;
                end else begin
                    m_out = mk_out(cur, p_mis, 1'b0);
                end
            end
            chk_out("rnd", m_out);
            if (accepted) begin
                rand_instr(cur); present(cur);
            end
        end
        dram_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_memp_stage7.md
Name: pipeline_memp_stage7

Overview:
- Memory-prepare stage, directly upstream of the DRAM/peripheral read stage (stage 8) and downstream of execute.
- Decodes the ALU-computed address into DRAM or system-bus space, aligns store data and byte masks, and issues requests.
- DRAM requests use a req/ack handshake through a small FSM; system-bus accesses complete in one cycle.
- Registers the control/data bundle that stage 8 consumes (the *_MEMP signals) and raises a stall request while a DRAM request is unaccepted.

Parameters:
- DRAM_BASE, 64'h0000_0000_8000_0000, first byte address of DRAM.
- DRAM_SIZE, 64'h0000_0000_0800_0000, DRAM region size in bytes; DRAM hit when DRAM_BASE <= addr < DRAM_BASE+DRAM_SIZE.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  global pipeline stall from hazard unit
- pc_MEM  in  64  PC of instruction from execute
- rf_wr_sel_MEM  in  2  writeback data select
- rf_wr_en_MEM  in  1  register write enable
- alu_result_MEM  in  64  ALU result / memory address
- rd_MEM  in  5  destination register
- mem_rd_en_MEM  in  1  load
- mem_wr_en_MEM  in  1  store
- mem_size_MEM  in  2  00 byte, 01 half, 10 word, 11 double
- store_data_MEM  in  64  rs2 value, LSB-justified
- dram_req  out  1  DRAM request valid
- dram_we  out  1  1 = write
- dram_addr  out  64  8-byte-aligned address
- dram_wdata  out  64  lane-aligned store data
- dram_wmask  out  8  byte enables
- dram_ack  in  1  DRAM accepted request this cycle
- sys_bus_re  out  1  peripheral read strobe
- sys_bus_we  out  1  peripheral write strobe
- sys_bus_addr  out  64  peripheral byte address
- sys_bus_wdata  out  64  lane-aligned store data
- sys_bus_wmask  out  8  byte enables
- stall_req  out  1  to hazard unit: hold upstream stages
- misalign_MEMP  out  1  registered misaligned-access flag
- is_dram_MEMP  out  1  registered: access targets DRAM
- pc_MEMP  out  64  registered PC
- rf_wr_sel_MEMP  out  2  registered
- rf_wr_en_MEMP  out  1  registered
- alu_result_MEMP  out  64  registered
- rd_MEMP  out  5  registered

Behaviour:
- Reset (reset==0, async): FSM to IDLE; all registered outputs 0; dram_req 0; hold buffer empty.
- Access: acc = mem_rd_en_MEM | mem_wr_en_MEM. Address A = alu_result_MEM; off = A[2:0].
- Masks: byte = 8'h01<<off; half = 8'h03<<off; word = 8'h0F<<off; double = 8'hFF.
- Wdata: store_data_MEM << (off*8).
- Misaligned when half & A[0], word & A[1:0]!=0, or double & off!=0. A misaligned access issues no request and sets misalign_MEMP; the bundle still advances with rf_wr_en_MEMP forced to 0.
- Sys-bus path (acc, not DRAM, aligned): strobes, addr, wdata and wmask are combinational and valid only while ~stall & state==IDLE. Bundle registers next edge; 1-cycle latency; is_dram_MEMP=0.
- FSM states:
  - IDLE: DRAM access, aligned, ~stall -> REQ. Request fields (address as {A[63:3],3'b0}) latch at the transition.
  - REQ: dram_req=1 with fields stable until dram_ack. stall_req=1. A stall arriving in REQ does not drop dram_req.
  - On dram_ack & ~stall: bundle registers with is_dram_MEMP=1; go to IDLE.
  - On dram_ack & stall: bundle goes to the hold buffer; go to HOLD.
  - HOLD: dram_req=0, stall_req=1. When ~stall, the buffer drives the output registers; go to IDLE.
- Same-cycle dram_ack in IDLE: impossible; ignored.
- Bubble insertion: while in REQ/HOLD and ~stall, output registers load a bubble (rf_wr_en=0, is_dram=0, rd=0, misalign=0) so stage 8 never sees a duplicated instruction.
- Output register update: on ~stall when IDLE with no DRAM issue, on ack, or on HOLD release. When stall=1, outputs hold.
- Non-memory instructions pass through with 1-cycle latency; is_dram_MEMP=0.
- stall_req is combinational: (state==REQ) | (state==HOLD) | (state==IDLE & DRAM issue this cycle).

Decomposition:
- Shared package rvcpu_mem_pkg: mem_size_e enum (BYTE/HALF/WORD/DOUBLE), memp_state_e (IDLE/REQ/HOLD), DRAM_BASE/DRAM_SIZE defaults.
- One sub-module: store_align (combinational: addr[2:0], size, data -> wmask, wdata, misalign), shared with any future store path.

Test Plan:
- ALU-only op, pc=0x80000010, rd=5 -> next edge pc_MEMP=0x80000010, rd_MEMP=5, is_dram_MEMP=0, no strobes.
- Store byte 0xAB to 0x80000003, dram_ack after 3 cycles -> dram_req high 3 cycles, dram_addr=0x80000000, wmask=0x08, wdata[31:24]=0xAB, stall_req high, bubbles emitted, then is_dram_MEMP=1.
- Load word from 0x10000004 (peripheral) -> sys_bus_re=1 same cycle, addr=0x10000004, no stall_req, is_dram_MEMP=0.
- Load half from 0x80000001 -> no dram_req, misalign_MEMP=1, rf_wr_en_MEMP=0.
- DRAM load with stall asserted during REQ, ack while stalled -> dram_req stays high until ack, HOLD entered, bundle released on first ~stall cycle.
- reset driven low while in REQ -> dram_req and all outputs 0 immediately, FSM IDLE after release.
